// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its flush sequencer.
// byte_merge works on a fixed maximum width; callers zero-extend and truncate (WIDTH up to 256).
package regfile_pkg;

    localparam int RF_MAX_W = 256;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_e;

    function automatic logic [RF_MAX_W-1:0] byte_merge(
        input logic [RF_MAX_W-1:0]   old_v,
        input logic [RF_MAX_W-1:0]   new_v,
        input logic [RF_MAX_W/8-1:0] be
    );
        logic [RF_MAX_W-1:0] r;
        r = old_v;
        for (int j = 0; j < RF_MAX_W/8; j++) begin
            if (be[j]) begin
                r[8*j +: 8] = new_v[8*j +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_flush_seq.sv
// Flush sequencer: walks an index over every entry, one per cycle, strobing a clear.
// busy/done are registered; clear_o is simply "in SWEEP" so the array clears index_o at each edge.
module regfile_flush_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] index_o,
    output logic          clear_o
);

    rf_state_e     state_q;
    logic [AW-1:0] index_q;
    logic          busy_q;
    logic          done_q;

    // flush arriving mid-sweep is deliberately ignored; only IDLE looks at it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RF_IDLE;
            index_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RF_IDLE: begin
                    if (flush_i) begin
                        state_q <= RF_SWEEP;
                        index_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RF_SWEEP: begin
                    if (index_q == AW'(DEPTH-1)) begin
                        state_q <= RF_IDLE;
                        index_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        index_q <= index_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= RF_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign index_o = index_q;
    assign clear_o = (state_q == RF_SWEEP);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with byte-enable writes, optional zero register,
// same-cycle write bypass and a sequenced flush that clears one entry per cycle.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NR*AW-1:0]      raddr,
    output logic [NR*WIDTH-1:0]   rdata,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wbe,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_d;
    logic             wr_hit;
    logic             clear;
    logic [AW-1:0]    sweep_idx;
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    regfile_flush_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_flush_seq (
        .clock   (clock),
        .reset   (reset),
        .flush_i (flush),
        .busy_o  (busy),
        .done_o  (done),
        .index_o (sweep_idx),
        .clear_o (clear)
    );

    // The merged word feeds both the array write and the bypass path, so they always agree
    always_comb begin
        wr_old = '0;
        if (in_range(waddr)) begin
            wr_old = mem_q[waddr];
        end
        wr_d   = WIDTH'(byte_merge(RF_MAX_W'(wr_old), RF_MAX_W'(wdata), (RF_MAX_W/8)'(wbe)));
        wr_hit = we && !busy && in_range(waddr) && !is_zero_reg(waddr);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            mem_q[sweep_idx] <= '0;
        end else if (wr_hit) begin
            mem_q[waddr] <= wr_d;
        end
    end

    // Zero-register forcing is applied last so it overrides any bypass
    always_comb begin
        rdata = '0;
        ra    = '0;
        rd    = '0;
        for (int k = 0; k < NR; k++) begin
            ra = raddr[k*AW +: AW];
            rd = '0;
            if (in_range(ra)) begin
                rd = mem_q[ra];
            end
            if ((BYPASS != 0) && wr_hit && (ra == waddr)) begin
                rd = wr_d;
            end
            if (is_zero_reg(ra)) begin
                rd = '0;
            end
            rdata[k*WIDTH +: WIDTH] = rd;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (zero reg + bypass) and an alternate one without
// either, both driven by the same stimulus; expected words go through a FIFO scoreboard.
module tb_regfile_mp;

    localparam int W   = 32;
    localparam int D   = 32;
    localparam int NRP = 2;
    localparam int AW  = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic [NRP*AW-1:0] raddr;
    logic [NRP*W-1:0] rdata;
    logic [NRP*W-1:0] rdata_alt;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [W-1:0]     wdata;
    logic [W/8-1:0]   wbe;
    logic             flush;
    logic             busy, done, busy_alt, done_alt;

    int               vectors = 0;
    int               miscompares = 0;
    logic [31:0]      expQ[$];
    logic [31:0]      expv, obs;

    always #5 clock = ~clock;

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NR(NRP), .ZERO_REG(1), .BYPASS(1)) dut (
        .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata), .we(we), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .flush(flush), .busy(busy), .done(done)
    );

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NR(NRP), .ZERO_REG(0), .BYPASS(0)) dut_alt (
        .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata_alt), .we(we), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .flush(flush), .busy(busy_alt), .done(done_alt)
    );

    function automatic logic [31:0] port(input logic [NRP*W-1:0] v, input int k);
        return v[k*W +: W];
    endfunction

    task automatic setRead(input int a0, input int a1);
        raddr = {AW'(a1), AW'(a0)};
    endtask

    task automatic stepEdge();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; we = 1'b0; flush = 1'b0; raddr = '0; waddr = '0; wdata = '0; wbe = '0;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || busy_alt !== 1'b0 || done_alt !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags busy=%b done=%b busy_alt=%b done_alt=%b, want all 0",
                     busy, done, busy_alt, done_alt);
        end
        #2 reset = 1'b1;
        stepEdge();
        for (int a = 0; a < D; a++) begin
            setRead(a, D-1-a);
            #1;
            for (int k = 0; k < NRP; k++) begin
                expQ.push_back(32'h0);
                expv = expQ.pop_front(); obs = port(rdata, k); vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("[TB] FAIL reset_read port%0d addr%0d got %h want %h", k, (k == 0) ? a : D-1-a, obs, expv);
                end
            end
            expQ.push_back(32'h0);
            expv = expQ.pop_front(); obs = port(rdata_alt, 0); vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL reset_read_alt addr%0d got %h want %h", a, obs, expv);
            end
        end
    endtask

    task automatic test_write_bypass();
        stepEdge();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wbe = 4'hF; setRead(0, 5);
        expQ.push_back(32'hDEADBEEF);
        expQ.push_back(32'h0);
        #1;
        expv = expQ.pop_front(); obs = port(rdata, 1); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL bypass_same_cycle got %h want %h", obs, expv); end
        expv = expQ.pop_front(); obs = port(rdata_alt, 1); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL nobypass_same_cycle got %h want %h", obs, expv); end
        stepEdge();
        we = 1'b0; setRead(5, 0);
        expQ.push_back(32'hDEADBEEF);
        expQ.push_back(32'hDEADBEEF);
        #1;
        expv = expQ.pop_front(); obs = port(rdata, 0); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL write_next_cycle got %h want %h", obs, expv); end
        expv = expQ.pop_front(); obs = port(rdata_alt, 0); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL write_next_cycle_alt got %h want %h", obs, expv); end
    endtask

    task automatic test_byte_enable();
        stepEdge();
        we = 1'b1; waddr = 5'd5; wdata = 32'h11223344; wbe = 4'b0101; setRead(0, 5);
        expQ.push_back(32'hDE22BE44);
        expQ.push_back(32'hDEADBEEF);
        #1;
        expv = expQ.pop_front(); obs = port(rdata, 1); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL be_bypass got %h want %h", obs, expv); end
        expv = expQ.pop_front(); obs = port(rdata_alt, 1); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL be_old_alt got %h want %h", obs, expv); end
        stepEdge();
        wdata = 32'hFFFFFFFF; wbe = 4'b0000; setRead(5, 5);
        expQ.push_back(32'hDE22BE44);
        expQ.push_back(32'hDE22BE44);
        #1;
        expv = expQ.pop_front(); obs = port(rdata, 1); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL be_zero_bypass got %h want %h", obs, expv); end
        expv = expQ.pop_front(); obs = port(rdata_alt, 0); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL be_merge_alt got %h want %h", obs, expv); end
        stepEdge();
        we = 1'b0;
        expQ.push_back(32'hDE22BE44);
        expQ.push_back(32'hDE22BE44);
        #1;
        expv = expQ.pop_front(); obs = port(rdata, 0); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL be_zero_noop got %h want %h", obs, expv); end
        expv = expQ.pop_front(); obs = port(rdata_alt, 1); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL be_zero_noop_alt got %h want %h", obs, expv); end
    endtask

    task automatic test_zero_reg();
        stepEdge();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wbe = 4'hF; setRead(0, 0);
        expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        #1;
        expv = expQ.pop_front(); obs = port(rdata, 1); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL zero_reg_same_cycle got %h want %h", obs, expv); end
        expv = expQ.pop_front(); obs = port(rdata_alt, 0); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL r0_alt_same_cycle got %h want %h", obs, expv); end
        stepEdge();
        we = 1'b0;
        expQ.push_back(32'h0);
        expQ.push_back(32'hFFFFFFFF);
        #1;
        expv = expQ.pop_front(); obs = port(rdata, 0); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL zero_reg_after_edge got %h want %h", obs, expv); end
        expv = expQ.pop_front(); obs = port(rdata_alt, 0); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL r0_alt_after_edge got %h want %h", obs, expv); end
    endtask

    task automatic test_flush_sweep();
        stepEdge();
        for (int i = 0; i < D; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = 32'(i + 1); wbe = 4'hF;
            stepEdge();
        end
        we = 1'b0; setRead(7, 0);
        expQ.push_back(32'd8);
        expQ.push_back(32'd0);
        expQ.push_back(32'd1);
        #1;
        expv = expQ.pop_front(); obs = port(rdata, 0); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL fill_r7 got %h want %h", obs, expv); end
        expv = expQ.pop_front(); obs = port(rdata, 1); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL fill_r0 got %h want %h", obs, expv); end
        expv = expQ.pop_front(); obs = port(rdata_alt, 1); vectors++;
        if (obs !== expv) begin miscompares++; $display("[TB] FAIL fill_r0_alt got %h want %h", obs, expv); end

        flush = 1'b1;
        stepEdge();
        for (int s = 0; s <= 34; s++) begin
            vectors++;
            if (busy !== (s <= 31) || done !== (s == 32) || busy_alt !== busy || done_alt !== done) begin
                miscompares++;
                $display("[TB] FAIL sweep_flags s=%0d busy=%b done=%b alt=%b%b want busy=%b done=%b",
                         s, busy, done, busy_alt, done_alt, (s <= 31), (s == 32));
            end
            we = 1'b0; flush = 1'b0;
            if (s == 3) begin
                we = 1'b1; waddr = 5'd31; wdata = 32'hABCD0000; wbe = 4'hF; setRead(2, 31);
                expQ.push_back(32'h0);
                expQ.push_back(32'd32);
                #1;
                expv = expQ.pop_front(); obs = port(rdata, 0); vectors++;
                if (obs !== expv) begin miscompares++; $display("[TB] FAIL sweep_cleared_r2 got %h want %h", obs, expv); end
                expv = expQ.pop_front(); obs = port(rdata, 1); vectors++;
                if (obs !== expv) begin miscompares++; $display("[TB] FAIL sweep_no_bypass_r31 got %h want %h", obs, expv); end
            end
            if (s == 5) flush = 1'b1;
            if (s == 10) begin
                setRead(31, 9);
                expQ.push_back(32'd32);
                expQ.push_back(32'h0);
                #1;
                expv = expQ.pop_front(); obs = port(rdata, 0); vectors++;
                if (obs !== expv) begin miscompares++; $display("[TB] FAIL sweep_write_dropped got %h want %h", obs, expv); end
                expv = expQ.pop_front(); obs = port(rdata, 1); vectors++;
                if (obs !== expv) begin miscompares++; $display("[TB] FAIL sweep_cleared_r9 got %h want %h", obs, expv); end
            end
            stepEdge();
        end
        we = 1'b0; flush = 1'b0;
        for (int a = 0; a < D; a++) begin
            setRead(a, a);
            expQ.push_back(32'h0);
            expQ.push_back(32'h0);
            #1;
            expv = expQ.pop_front(); obs = port(rdata, 0); vectors++;
            if (obs !== expv) begin miscompares++; $display("[TB] FAIL post_flush r%0d got %h want %h", a, obs, expv); end
            expv = expQ.pop_front(); obs = port(rdata_alt, 1); vectors++;
            if (obs !== expv) begin miscompares++; $display("[TB] FAIL post_flush_alt r%0d got %h want %h", a, obs, expv); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        stepEdge();
        for (int i = 1; i <= 3; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = 32'h5A5A0000 | 32'(i); wbe = 4'hF;
            stepEdge();
        end
        we = 1'b0; flush = 1'b1;
        stepEdge();
        flush = 1'b0;
        repeat (10) stepEdge();
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || busy_alt !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midsweep_reset_flags busy=%b done=%b busy_alt=%b want 0", busy, done, busy_alt);
        end
        for (int a = 0; a < D; a++) begin
            setRead(a, a);
            expQ.push_back(32'h0);
            #1;
            expv = expQ.pop_front(); obs = port(rdata_alt, 1); vectors++;
            if (obs !== expv) begin miscompares++; $display("[TB] FAIL midsweep_reset_read r%0d got %h want %h", a, obs, expv); end
        end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 40; c++) begin
            stepEdge();
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL post_reset_idle c=%0d busy=%b done=%b want 0 0", c, busy, done);
            end
        end
        flush = 1'b1;
        stepEdge();
        for (int s = 0; s <= 33; s++) begin
            flush = 1'b0;
            vectors++;
            if (busy !== (s <= 31) || done !== (s == 32)) begin
                miscompares++;
                $display("[TB] FAIL fresh_sweep s=%0d busy=%b done=%b want busy=%b done=%b",
                         s, busy, done, (s <= 31), (s == 32));
            end
            stepEdge();
        end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_byte_enable();
        test_zero_reg();
        test_flush_sweep();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
